// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam int INIT_ZERO  = 0;
   localparam int INIT_INDEX = 1;

   // Index value truncated to the data width; callers resize to DATA_W.
   function automatic logic [31:0] init_val(input logic [31:0] index, input int data_w);
      logic [31:0] v;
      v = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < data_w) v[b] = index[b];
      end
      return v;
   endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset init sweep: walks every entry once, then hands the write port to the datapath.
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int INIT_MODE = INIT_INDEX
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              busy_o,
   output logic              init_we_o,
   output logic [ADDR_W-1:0] init_addr_o,
   output logic [DATA_W-1:0] init_data_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter wraps to zero on the last entry, ready for any later re-sweep.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_we_o = 1'b0;
      if (state_q == ST_INIT && !rst_i) begin
         init_we_o = 1'b1;
         cnt_d     = cnt_q + ADDR_W'(1);
         if (&cnt_q) state_d = ST_READY;
      end
   end

   assign busy_o      = rst_i | (state_q == ST_INIT);
   assign init_addr_o = cnt_q;
   assign init_data_o = (INIT_MODE == INIT_INDEX) ? DATA_W'(init_val(32'(cnt_q), DATA_W)) : '0;

endmodule

// File: rtl/regfile_np.sv
// Parametrised multi-read-port register file with byte-enable writes,
// optional hardwired zero entry, optional write bypass and a hardware init sweep.
module regfile_np
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int NRD       = 2,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1,
   parameter int INIT_MODE = INIT_INDEX
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RWE,
   input  logic [ADDR_W-1:0]     WA,
   input  logic [DATA_W-1:0]     WD,
   input  logic [DATA_W/8-1:0]   WBE,
   input  logic [NRD*ADDR_W-1:0] RA,
   output logic [NRD*DATA_W-1:0] RD,
   output logic                  BUSY
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int NBYTES = DATA_W/8;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              busy;
   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic [DATA_W-1:0] init_data;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [NBYTES-1:0] wr_be;

   regfile_init_seq #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .INIT_MODE (INIT_MODE)
   ) u_init_seq (
      .clk_i       (CLK),
      .rst_i       (RST),
      .busy_o      (busy),
      .init_we_o   (init_we),
      .init_addr_o (init_addr),
      .init_data_o (init_data)
   );

   assign BUSY = busy;

   // The sweep owns the write port while busy; user writes are dropped, not queued.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = WA;
      wr_data = WD;
      wr_be   = WBE;
      if (init_we) begin
         wr_en   = 1'b1;
         wr_addr = init_addr;
         wr_data = init_data;
         wr_be   = '1;
      end else if (!busy && RWE && !(ZERO_REG != 0 && WA == '0)) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = RA[p*ADDR_W +: ADDR_W];

      // Bypass merges written bytes over the stored word; zero masking wins over everything.
      always_comb begin
         rd = mem_q[ra];
         if (BYPASS != 0 && !busy && RWE && WA == ra) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (WBE[b]) rd[8*b +: 8] = WD[8*b +: 8];
            end
         end
         if (busy || (ZERO_REG != 0 && ra == '0)) rd = '0;
      end

      assign RD[p*DATA_W +: DATA_W] = rd;
   end

endmodule
